// File: rtl/reg_scoreboard_decoder.sv
// Register-file scoreboard for the rv32i core.
// A generic N-way decoder turns issue and writeback addresses into masks.
// The masks drive a registered busy vector, its popcount and a one-hot
// regfile write-enable. Source-operand hazards are reported combinationally.

// Generalised N-way address decoder: one-hot output when enabled, zero otherwise
module nway_decoder #(
   parameter int N      = 32,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [N-1:0]      onehot
);

   // Raise exactly the addressed line when the request is valid
   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[addr] = 1'b1;
      end
   end

endmodule

module reg_scoreboard_decoder #(
   parameter int N_REGS     = 32,
   parameter int ADDR_W     = $clog2(N_REGS),
   parameter bit ZERO_HARD  = 1'b1,
   parameter bit BYPASS_CLR = 1'b1,
   localparam int CNT_W     = $clog2(N_REGS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              set_valid,
   input  logic [ADDR_W-1:0] set_addr,
   input  logic              clr_valid,
   input  logic [ADDR_W-1:0] clr_addr,
   input  logic              flush,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic              stall,
   output logic [N_REGS-1:0] busy_vec,
   output logic [CNT_W-1:0]  busy_count,
   output logic [N_REGS-1:0] wb_we
);

   logic [N_REGS-1:0] set_raw;
   logic [N_REGS-1:0] clr_raw;
   logic [N_REGS-1:0] set_mask;
   logic [N_REGS-1:0] clr_mask;
   logic [N_REGS-1:0] busy_next;
   logic [CNT_W-1:0]  count_next;

   nway_decoder #(
      .N      (N_REGS),
      .ADDR_W (ADDR_W)
   ) u_set_dec (
      .en     (set_valid),
      .addr   (set_addr),
      .onehot (set_raw)
   );

   nway_decoder #(
      .N      (N_REGS),
      .ADDR_W (ADDR_W)
   ) u_clr_dec (
      .en     (clr_valid),
      .addr   (clr_addr),
      .onehot (clr_raw)
   );

   // Strip register 0 from both masks when it is hardwired, so x0 never
   // becomes busy and is never written back
   always_comb begin
      set_mask = set_raw;
      clr_mask = clr_raw;
      if (ZERO_HARD) begin
         set_mask[0] = 1'b0;
         clr_mask[0] = 1'b0;
      end
   end

   // Flush wipes everything; otherwise clear the written-back bit first and
   // then set the newly issued one, so a same-cycle set/clr leaves it busy
   always_comb begin
      busy_next = (busy_vec & ~clr_mask) | set_mask;
      if (flush) begin
         busy_next = '0;
      end
      if (ZERO_HARD) begin
         busy_next[0] = 1'b0;
      end
   end

   // Popcount of the next busy vector so the registered count tracks it exactly
   always_comb begin
      count_next = '0;
      for (int i = 0; i < N_REGS; i++) begin
         count_next = count_next + CNT_W'(busy_next[i]);
      end
   end

   // State register: everything frozen while ena is low; wb_we follows the
   // clear mask even during a flush because the writeback still happens
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_vec   <= '0;
         busy_count <= '0;
         wb_we      <= '0;
      end else if (ena) begin
         busy_vec   <= busy_next;
         busy_count <= count_next;
         wb_we      <= clr_mask;
      end
   end

   // Hazard lookup: a same-cycle writeback may forward and hide the hazard,
   // while a same-cycle issue only shows up next cycle
   function automatic logic rs_lookup(input logic [ADDR_W-1:0] addr);
      logic hit;
      hit = busy_vec[addr];
      if (BYPASS_CLR && clr_mask[addr]) begin
         hit = 1'b0;
      end
      if (ZERO_HARD && (addr == '0)) begin
         hit = 1'b0;
      end
      return hit;
   endfunction

   // Source-operand hazard outputs for the issue stage
   always_comb begin
      rs1_busy = rs_lookup(rs1_addr);
      rs2_busy = rs_lookup(rs2_addr);
      stall    = rs1_busy | rs2_busy;
   end

endmodule

// File: tb/tb_reg_scoreboard_decoder.sv
// Self-checking bench for reg_scoreboard_decoder with a behavioural model.
module tb_reg_scoreboard_decoder;

   localparam int N = 32;
   localparam int AW = 5;
   localparam int CW = 6;

   logic          clk;
   logic          rst_n;
   logic          ena;
   logic          set_valid;
   logic [AW-1:0] set_addr;
   logic          clr_valid;
   logic [AW-1:0] clr_addr;
   logic          flush;
   logic [AW-1:0] rs1_addr;
   logic [AW-1:0] rs2_addr;
   logic          rs1_busy;
   logic          rs2_busy;
   logic          stall;
   logic [N-1:0]  busy_vec;
   logic [CW-1:0] busy_count;
   logic [N-1:0]  wb_we;

   int total;
   int bad;

   bit mBusy [N];
   int mWe;

   reg_scoreboard_decoder #(
      .N_REGS     (N),
      .ZERO_HARD  (1'b1),
      .BYPASS_CLR (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .set_valid  (set_valid),
      .set_addr   (set_addr),
      .clr_valid  (clr_valid),
      .clr_addr   (clr_addr),
      .flush      (flush),
      .rs1_addr   (rs1_addr),
      .rs2_addr   (rs2_addr),
      .rs1_busy   (rs1_busy),
      .rs2_busy   (rs2_busy),
      .stall      (stall),
      .busy_vec   (busy_vec),
      .busy_count (busy_count),
      .wb_we      (wb_we)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [N-1:0] modelVec();
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         if (mBusy[i]) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic int modelCount();
      int c;
      c = 0;
      for (int i = 0; i < N; i++) begin
         if (mBusy[i]) c++;
      end
      return c;
   endfunction

   function automatic logic [N-1:0] modelWe();
      logic [N-1:0] v;
      v = '0;
      if (mWe >= 0) v[mWe] = 1'b1;
      return v;
   endfunction

   function automatic logic modelRs(input int addr);
      if (addr == 0) return 1'b0;
      if (clr_valid && (int'(clr_addr) == addr)) return 1'b0;
      return logic'(mBusy[addr]);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < N; i++) mBusy[i] = 1'b0;
      mWe = -1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkComb(input string tag);
      checkOutput({tag, ".rs1_busy"}, 64'(rs1_busy), 64'(modelRs(int'(rs1_addr))));
      checkOutput({tag, ".rs2_busy"}, 64'(rs2_busy), 64'(modelRs(int'(rs2_addr))));
      checkOutput({tag, ".stall"}, 64'(stall),
                  64'(modelRs(int'(rs1_addr)) | modelRs(int'(rs2_addr))));
   endtask

   task automatic checkRegs(input string tag);
      checkOutput({tag, ".busy_vec"}, 64'(busy_vec), 64'(modelVec()));
      checkOutput({tag, ".busy_count"}, 64'(busy_count), 64'(modelCount()));
      checkOutput({tag, ".wb_we"}, 64'(wb_we), 64'(modelWe()));
   endtask

   // Drive one cycle of inputs, check the combinational hazards before the
   // edge, advance the model at the edge, then check the registered state
   task automatic applyStimulus(input string tag, input logic e, input logic sv,
                                input int sa, input logic cv, input int ca,
                                input logic fl, input int r1, input int r2);
      ena       = e;
      set_valid = sv;
      set_addr  = AW'(sa);
      clr_valid = cv;
      clr_addr  = AW'(ca);
      flush     = fl;
      rs1_addr  = AW'(r1);
      rs2_addr  = AW'(r2);
      #1;
      checkComb(tag);
      @(posedge clk);
      if (e) begin
         mWe = (cv && ca != 0) ? ca : -1;
         if (fl) begin
            for (int i = 0; i < N; i++) mBusy[i] = 1'b0;
         end else begin
            if (cv) mBusy[ca] = 1'b0;
            if (sv && sa != 0) mBusy[sa] = 1'b1;
         end
      end
      #1;
      checkRegs(tag);
   endtask

   task automatic idle(input string tag);
      applyStimulus(tag, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      modelReset();
      rst_n = 1'b0;
      ena = 1'b0; set_valid = 1'b0; set_addr = '0; clr_valid = 1'b0;
      clr_addr = '0; flush = 1'b0; rs1_addr = '0; rs2_addr = '0;
      #12;
      checkRegs("reset");
      checkComb("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Set x5, hazard only visible the following cycle
      applyStimulus("t2c0", 1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 5, 0);
      checkOutput("t2.vec20", 64'(busy_vec), 64'h20);
      applyStimulus("t2c1", 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 5, 0);

      // Writeback x5 forwards and clears the hazard in the same cycle
      applyStimulus("t3c0", 1'b1, 1'b0, 0, 1'b1, 5, 1'b0, 0, 5);
      checkOutput("t3.we20", 64'(wb_we), 64'h20);
      idle("t3c1");

      // Same-cycle set and clear of x7: stays busy
      applyStimulus("t4a", 1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 7, 0);
      applyStimulus("t4b", 1'b1, 1'b1, 7, 1'b1, 7, 1'b0, 7, 7);
      checkOutput("t4.we80", 64'(wb_we), 64'h80);
      applyStimulus("t4waw", 1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 7, 3);

      // Frozen for three cycles with every request active
      for (int k = 0; k < 3; k++) begin
         applyStimulus("t6freeze", 1'b0, 1'b1, 9, 1'b1, 7, 1'b1, 7, 9);
      end

      // Fill every register except x0, then flush with a simultaneous set
      for (int r = 0; r < N; r++) begin
         applyStimulus("t5fill", 1'b1, 1'b1, r, 1'b0, 0, 1'b0, 0, r);
      end
      checkOutput("t5.full", 64'(busy_vec), 64'hFFFF_FFFE);
      checkOutput("t5.cnt31", 64'(busy_count), 64'd31);
      applyStimulus("t5flush", 1'b1, 1'b1, 3, 1'b0, 0, 1'b1, 3, 1);
      checkOutput("t5.empty", 64'(busy_vec), 64'h0);
      applyStimulus("t5x0", 1'b1, 1'b1, 0, 1'b1, 0, 1'b0, 0, 0);

      // Build 0xF0, pulse wb_we on a non-busy register, then async reset
      for (int r = 4; r < 8; r++) begin
         applyStimulus("t1fill", 1'b1, 1'b1, r, 1'b0, 0, 1'b0, r, 0);
      end
      applyStimulus("t1clr9", 1'b1, 1'b0, 0, 1'b1, 9, 1'b0, 4, 9);
      checkOutput("t1.vecF0", 64'(busy_vec), 64'hF0);
      ena = 1'b1; set_valid = 1'b0; clr_valid = 1'b0; flush = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkRegs("t1async");
      checkComb("t1async");
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkRegs("t1after");

      // Randomised traffic against the model
      for (int k = 0; k < 400; k++) begin
         applyStimulus("rand",
                       logic'($urandom_range(0, 9) != 0),
                       logic'($urandom_range(0, 1)),
                       int'($urandom_range(0, N - 1)),
                       logic'($urandom_range(0, 2) == 0),
                       int'($urandom_range(0, N - 1)),
                       logic'($urandom_range(0, 39) == 0),
                       int'($urandom_range(0, N - 1)),
                       int'($urandom_range(0, N - 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
